// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_ctrl_pkg                                                    |
// | Shared encodings for the pipeline sequencing controller.         |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package pipe_ctrl_pkg;

    localparam logic [1:0] PC_SEL_SEQ  = 2'd0;
    localparam logic [1:0] PC_SEL_REL  = 2'd1;
    localparam logic [1:0] PC_SEL_JALR = 2'd2;

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_REL  = 2'd1;
    localparam logic [1:0] BR_JALR = 2'd2;

    localparam logic [1:0] PCTL_RUN     = 2'd0;
    localparam logic [1:0] PCTL_FLUSH   = 2'd1;
    localparam logic [1:0] PCTL_MEMWAIT = 2'd2;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Code 3 is reserved in the ALU encoding and must never redirect.
    function automatic logic is_redirect(input logic [1:0] br);
        return (br == BR_REL) || (br == BR_JALR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_ctrl_hazard_detect                                          |
// | Combinational load-use detector between EX and ID.               |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module pipe_ctrl_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    output logic       load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign w_rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    assign load_use  = ex_valid && ex_is_load && (ex_rd != REG_X0) && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_ctrl                                                        |
// | Pipeline sequencing controller: redirect, flush, load-use and    |
// | memory-wait policy. Perf counters enabled by PIPE_CTRL_PERF_EN.  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [1:0]       ex_br_taken,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             dmem_busy,
    output logic [1:0]       pc_sel,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    localparam logic [2:0] c_flush_reload = 3'(FLUSH_DEPTH - 1);

    logic [1:0] r_state;
    logic [1:0] r_resume;
    logic [2:0] r_cnt;
    logic [1:0] w_state_nxt;
    logic [1:0] w_resume_nxt;
    logic [2:0] w_cnt_nxt;
    logic [1:0] w_eff;
    logic       w_load_use;
    logic       w_redirect;

    pipe_ctrl_hazard_detect u_hazard (
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .load_use   (w_load_use)
    );

    // While waiting on memory the saved state is the one that governs behaviour.
    assign w_eff      = (r_state == PCTL_MEMWAIT) ? r_resume : r_state;
    assign w_redirect = ex_valid && is_redirect(ex_br_taken);

    always_comb begin
        pc_sel       = PC_SEL_SEQ;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        w_state_nxt  = w_eff;
        w_resume_nxt = r_resume;
        w_cnt_nxt    = r_cnt;
        if (rst) begin
            w_state_nxt  = PCTL_RUN;
            w_resume_nxt = PCTL_RUN;
            w_cnt_nxt    = 3'd0;
        end else if (dmem_busy) begin
            pipe_freeze  = 1'b1;
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            w_state_nxt  = PCTL_MEMWAIT;
            w_resume_nxt = w_eff;
        end else if (w_redirect) begin
            pc_sel       = (ex_br_taken == BR_JALR) ? PC_SEL_JALR : PC_SEL_REL;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (FLUSH_DEPTH > 1) begin
                w_state_nxt = PCTL_FLUSH;
                w_cnt_nxt   = c_flush_reload;
            end else begin
                w_state_nxt = PCTL_RUN;
                w_cnt_nxt   = 3'd0;
            end
        end else if (w_eff == PCTL_FLUSH) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (r_cnt <= 3'd1) begin
                w_state_nxt = PCTL_RUN;
                w_cnt_nxt   = 3'd0;
            end else begin
                w_cnt_nxt   = r_cnt - 3'd1;
            end
        end else if (w_load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= PCTL_RUN;
            r_resume <= PCTL_RUN;
            r_cnt    <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_resume <= w_resume_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (pc_stall) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_redirect && !dmem_busy) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pipe_ctrl                                                     |
// | Directed and random checks of pipe_ctrl at FLUSH_DEPTH 2 and 3.  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_valid;
    logic [1:0] ex_br_taken;
    logic       ex_is_load;
    logic [4:0] ex_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       dmem_busy;

    logic [1:0]  pc_sel_2, pc_sel_3;
    logic        pc_stall_2, pc_stall_3, if_id_stall_2, if_id_stall_3;
    logic        if_id_flush_2, if_id_flush_3, id_ex_bubble_2, id_ex_bubble_3;
    logic        pipe_freeze_2, pipe_freeze_3;
    logic [31:0] ps_2, pf_2, ps_3, pf_3;

    // Output vector layout: {pc_sel, pc_stall, if_id_stall, if_id_flush, id_ex_bubble, pipe_freeze}
    logic [6:0] o2, o3, e2, e3;
    int         left2, left3, nl2, nl3;
    logic [31:0] ms2, mf2, ms3, mf3;
    int         vectors = 0;
    int         miscompares = 0;

    assign o2 = {pc_sel_2, pc_stall_2, if_id_stall_2, if_id_flush_2, id_ex_bubble_2, pipe_freeze_2};
    assign o3 = {pc_sel_3, pc_stall_3, if_id_stall_3, if_id_flush_3, id_ex_bubble_3, pipe_freeze_3};

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_DEPTH(2), .CNT_W(32)) u_dut2 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_br_taken(ex_br_taken),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .dmem_busy(dmem_busy),
        .pc_sel(pc_sel_2), .pc_stall(pc_stall_2), .if_id_stall(if_id_stall_2),
        .if_id_flush(if_id_flush_2), .id_ex_bubble(id_ex_bubble_2), .pipe_freeze(pipe_freeze_2),
        .perf_stall_cnt(ps_2), .perf_flush_cnt(pf_2)
    );

    pipe_ctrl #(.FLUSH_DEPTH(3), .CNT_W(32)) u_dut3 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_br_taken(ex_br_taken),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .dmem_busy(dmem_busy),
        .pc_sel(pc_sel_3), .pc_stall(pc_stall_3), .if_id_stall(if_id_stall_3),
        .if_id_flush(if_id_flush_3), .id_ex_bubble(id_ex_bubble_3), .pipe_freeze(pipe_freeze_3),
        .perf_stall_cnt(ps_3), .perf_flush_cnt(pf_3)
    );

    // Reference: 'left' is the number of flush cycles still owed after this one.
    task automatic model(input int depth, input int left, output logic [6:0] v, output int nl);
        logic redir;
        logic lu;
        redir = ex_valid && (ex_br_taken == 2'd1 || ex_br_taken == 2'd2);
        lu = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        v  = 7'b0;
        nl = left;
        if (rst) begin
            nl = 0;
        end else if (dmem_busy) begin
            v = 7'b0011001;
        end else if (redir) begin
            v  = {ex_br_taken, 5'b00110};
            nl = depth - 1;
        end else if (left > 0) begin
            v  = 7'b0000110;
            nl = left - 1;
        end else if (lu) begin
            v = 7'b0011010;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model(2, left2, e2, nl2);
        model(3, left3, e3, nl3);
    endtask

    task automatic tick();
        @(posedge clk);
        left2 = nl2;
        left3 = nl3;
        if (rst) begin
            ms2 = 0; mf2 = 0; ms3 = 0; mf3 = 0;
        end else begin
            ms2 = ms2 + 32'(e2[4]);
            mf2 = mf2 + 32'(e2[6:5] != 2'd0);
            ms3 = ms3 + 32'(e3[4]);
            mf3 = mf3 + 32'(e3[6:5] != 2'd0);
        end
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; ex_br_taken = 0; ex_is_load = 0; ex_rd = 0;
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; dmem_busy = 0;
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) begin
            settle();
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        ex_valid = 1; ex_br_taken = 2'd1; dmem_busy = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            if ({o2, o3} !== {e2, e3} || o2 !== 7'b0) begin
                miscompares++;
                $display("FAIL reset_hold got=%b/%b exp=%b/%b", o2, o3, e2, e3);
            end
            vectors++;
            tick();
        end
        rst = 0;
        idle();
        settle();
        if ({o2, o3} !== 14'b0) begin
            miscompares++;
            $display("FAIL reset_release got=%b/%b exp=0/0", o2, o3);
        end
        vectors++;
        tick();
    endtask

    task automatic test_load_use();
        idle();
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1;
        settle();
        if ({o2, o3} !== {e2, e3} || o2 !== 7'b0011010) begin
            miscompares++;
            $display("FAIL load_use got=%b/%b exp=%b/%b", o2, o3, e2, e3);
        end
        vectors++;
        tick();
        ex_is_load = 0;
        settle();
        if ({o2, o3} !== {e2, e3} || o2 !== 7'b0) begin
            miscompares++;
            $display("FAIL load_use_next got=%b/%b exp=%b/%b", o2, o3, e2, e3);
        end
        vectors++;
        tick();
        ex_is_load = 1; ex_rd = 5'd0; id_rs2 = 5'd0;
        settle();
        if ({o2, o3} !== {e2, e3} || o2 !== 7'b0) begin
            miscompares++;
            $display("FAIL load_use_x0 got=%b/%b exp=%b/%b", o2, o3, e2, e3);
        end
        vectors++;
        tick();
    endtask

    task automatic test_jal();
        idle();
        ex_valid = 1; ex_br_taken = 2'd1;
        for (int t = 0; t < 4; t++) begin
            settle();
            if ({o2, o3} !== {e2, e3}) begin
                miscompares++;
                $display("FAIL jal_t%0d got=%b/%b exp=%b/%b", t, o2, o3, e2, e3);
            end
            vectors++;
            tick();
            idle();
        end
    endtask

    task automatic test_jalr_in_flush();
        int bubbles3;
        bubbles3 = 0;
        idle();
        ex_valid = 1; ex_br_taken = 2'd1;
        settle();
        tick();
        ex_br_taken = 2'd2;
        for (int t = 0; t < 5; t++) begin
            settle();
            if ({o2, o3} !== {e2, e3}) begin
                miscompares++;
                $display("FAIL jalr_flush_t%0d got=%b/%b exp=%b/%b", t, o2, o3, e2, e3);
            end
            vectors++;
            bubbles3 += int'(id_ex_bubble_3);
            tick();
            idle();
        end
        if (bubbles3 !== 3) begin
            miscompares++;
            $display("FAIL jalr_bubble_count got=%0d exp=3", bubbles3);
        end
        vectors++;
    endtask

    task automatic test_mem_freeze();
        idle();
        ex_valid = 1; ex_br_taken = 2'd1;
        settle();
        tick();
        idle();
        dmem_busy = 1;
        for (int t = 0; t < 7; t++) begin
            if (t == 4) dmem_busy = 0;
            settle();
            if ({o2, o3} !== {e2, e3}) begin
                miscompares++;
                $display("FAIL mem_freeze_t%0d got=%b/%b exp=%b/%b", t, o2, o3, e2, e3);
            end
            vectors++;
            tick();
        end
    endtask

    task automatic test_collision();
        idle();
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1; ex_br_taken = 2'd1;
        settle();
        if ({o2, o3} !== {e2, e3} || pc_stall_2 !== 1'b0 || pc_sel_2 === 2'd0) begin
            miscompares++;
            $display("FAIL collision got=%b/%b exp=%b/%b", o2, o3, e2, e3);
        end
        vectors++;
        tick();
        drain(3);
    endtask

    task automatic test_reset_mid_flush();
        idle();
        ex_valid = 1; ex_br_taken = 2'd2;
        settle();
        tick();
        idle();
        rst = 1;
        settle();
        if ({o2, o3} !== 14'b0) begin
            miscompares++;
            $display("FAIL rst_in_flush got=%b/%b exp=0/0", o2, o3);
        end
        vectors++;
        tick();
        rst = 0;
        settle();
        if ({o2, o3} !== {e2, e3} || {o2, o3} !== 14'b0) begin
            miscompares++;
            $display("FAIL rst_after_flush got=%b/%b exp=0/0", o2, o3);
        end
        vectors++;
        tick();
    endtask

    task automatic test_perf();
        idle();
        rst = 1;
        settle();
        tick();
        rst = 0;
        ex_valid = 1; ex_br_taken = 2'd1;
        settle();
        tick();
        drain(3);
        ex_valid = 1; ex_br_taken = 2'd2;
        settle();
        tick();
        drain(3);
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1;
        settle();
        tick();
        idle();
        settle();
`ifdef PIPE_CTRL_PERF_EN
        if (pf_2 !== 32'd2 || ps_2 !== 32'd1 || pf_3 !== mf3 || ps_3 !== ms3) begin
            miscompares++;
            $display("FAIL perf_counts got=%0d,%0d/%0d,%0d exp=2,1/%0d,%0d", pf_2, ps_2, pf_3, ps_3, mf3, ms3);
        end
`else
        if ({pf_2, ps_2, pf_3, ps_3} !== 128'b0) begin
            miscompares++;
            $display("FAIL perf_tied_off got=%0d,%0d,%0d,%0d exp=0", pf_2, ps_2, pf_3, ps_3);
        end
`endif
        vectors++;
        tick();
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            rst         = ($urandom_range(0, 39) == 0);
            dmem_busy   = ($urandom_range(0, 4) == 0);
            ex_valid    = 1'($urandom_range(0, 1));
            ex_br_taken = 2'($urandom_range(0, 3));
            ex_is_load  = 1'($urandom_range(0, 1));
            ex_rd       = 5'($urandom_range(0, 3));
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            settle();
            if ({o2, o3} !== {e2, e3}) begin
                miscompares++;
                $display("FAIL random_%0d got=%b/%b exp=%b/%b", t, o2, o3, e2, e3);
            end
            vectors++;
            tick();
        end
        rst = 0;
        idle();
        settle();
`ifdef PIPE_CTRL_PERF_EN
        if ({ps_2, pf_2, ps_3, pf_3} !== {ms2, mf2, ms3, mf3}) begin
            miscompares++;
            $display("FAIL random_perf got=%0d,%0d/%0d,%0d exp=%0d,%0d/%0d,%0d",
                     ps_2, pf_2, ps_3, pf_3, ms2, mf2, ms3, mf3);
        end
        vectors++;
`endif
        tick();
    endtask

    initial begin
        left2 = 0; left3 = 0; nl2 = 0; nl3 = 0;
        ms2 = 0; mf2 = 0; ms3 = 0; mf3 = 0;
        e2 = 0; e3 = 0;
        rst = 1;
        idle();
        test_reset();
        test_load_use();
        test_jal();
        test_jalr_in_flush();
        test_mem_freeze();
        test_collision();
        test_reset_mid_flush();
        test_perf();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core around the EX-stage ALU. Consumes the ALU's 2-bit br_taken code, decode-stage register usage and data-memory busy. Drives PC select, stage stalls, flushes and bubbles. Owns the redirect-recovery and memory-wait state machine so that no other stage computes hazard policy.

Parameters:
FLUSH_DEPTH, 2, cycles of bubble injected into ID/EX after a redirect, counting the redirect cycle; legal range 1..7.
CNT_W, 32, width of perf counters (used only with PIPE_CTRL_PERF_EN).

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
ex_valid  in  1  EX holds a real instruction
ex_br_taken  in  2  ALU code: 0 none, 1 branch/JAL taken (PC-relative target), 2 JALR (register target), 3 reserved, treated as 0
ex_is_load  in  1  EX instruction is LB/LH/LW/LBU/LHU
ex_rd  in  5  EX destination register
id_rs1  in  5  ID source 1
id_rs2  in  5  ID source 2
id_use_rs1  in  1  ID reads rs1
id_use_rs2  in  1  ID reads rs2
dmem_busy  in  1  data memory not ready this cycle
pc_sel  out  2  0 pc+4, 1 PC-relative target, 2 JALR target
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID register
if_id_flush  out  1  invalidate IF/ID
id_ex_bubble  out  1  load NOP into ID/EX
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
perf_stall_cnt  out  CNT_W  stall-cycle count (feature only)
perf_flush_cnt  out  CNT_W  redirect count (feature only)

Behaviour:
- Clock clk; reset rst is synchronous and active-high. While rst=1, all outputs are 0 and the state becomes RUN with the flush counter at 0. Outputs are combinational from state plus inputs, and are forced to 0 while rst=1.
- States: RUN, FLUSH, MEMWAIT; 2-bit encoding; flush counter is 3 bits.
- Priority per cycle: dmem_busy > redirect > load-use.
- dmem_busy=1 (any state):
  - pipe_freeze=1, pc_stall=1, if_id_stall=1; all other outputs 0.
  - Enter MEMWAIT, retaining the prior state and counter for resume.
  - Redirect and load-use are not evaluated while frozen, because EX inputs are held stable.
- MEMWAIT: on dmem_busy=0, resume the saved state in that same cycle and evaluate it normally. No extra cycle is lost.
- Redirect: ex_valid=1 and ex_br_taken in {1,2}, in RUN or FLUSH.
  - pc_sel = ex_br_taken; if_id_flush=1; id_ex_bubble=1.
  - If FLUSH_DEPTH>1: go to FLUSH with counter = FLUSH_DEPTH-1. Otherwise stay in RUN.
  - A redirect arriving in FLUSH reloads the counter.
- FLUSH: id_ex_bubble=1 and if_id_flush=1 each cycle. Decrement the counter; at 1, return to RUN. Load-use is ignored.
- Load-use hazard: only in RUN with no redirect. Fires when ex_valid, ex_is_load, ex_rd!=0, and (id_use_rs1 and id_rs1==ex_rd, or id_use_rs2 and id_rs2==ex_rd).
  - Response: pc_stall=1, if_id_stall=1, id_ex_bubble=1 for exactly that cycle.
  - Next cycle the load has left EX, so the stall is not repeated.
- ex_br_taken=3 or ex_valid=0: no redirect; pc_sel=0.
- rst=1 mid-FLUSH or mid-MEMWAIT: go to RUN next cycle; the pending flush is discarded.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - perf_stall_cnt increments on every cycle with pc_stall=1.
  - perf_flush_cnt increments on every redirect cycle.
  - Both counters wrap modulo 2^CNT_W and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Decomposition:
- define.vh gains PC_SEL_SEQ/PC_SEL_REL/PC_SEL_JALR (2-bit), BR_NONE/BR_REL/BR_JALR matching the ALU br_taken encoding, and PCTL_RUN/PCTL_FLUSH/PCTL_MEMWAIT state codes.
- One combinational sub-module, hazard_detect: inputs ex_valid, ex_is_load, ex_rd, id_rs*, id_use_*; output load_use.

Test Plan:
- Load-use: LW x5 in EX (ex_rd=5), ID id_rs2=5, id_use_rs2=1 → exactly one cycle of pc_stall=if_id_stall=id_ex_bubble=1; 0 next cycle. Same stimulus with ex_rd=0 → no stall.
- JAL: ex_br_taken=1, ex_valid=1, FLUSH_DEPTH=2 → cycle t: pc_sel=1, if_id_flush=1, id_ex_bubble=1; t+1: bubble=1, pc_sel=0; t+2: state RUN, all 0.
- JALR during FLUSH with FLUSH_DEPTH=3 → pc_sel=2 and the counter reloads; total bubbles = 1 + 3.
- Memory freeze: dmem_busy high for 4 cycles while in FLUSH with counter=1 → pipe_freeze=1 for 4 cycles, then one more bubble cycle, then RUN.
- Collision: redirect and load-use matched in the same cycle → redirect wins; pc_stall=0 and pc_sel≠0.
- Reset: rst asserted in the middle of FLUSH → next cycle all outputs 0 and state RUN. With PIPE_CTRL_PERF_EN, two redirects plus one load-use → perf_flush_cnt=2, perf_stall_cnt=1.
